api_rx_filter: RTL and testbench
================================

Name: api_rx_filter

Overview:
Downstream consumer of the API controller's RX FIFO. Each miner chip returns an 11-word readback block, and the controller writes it into the RX FIFO. This block pops the FIFO one block at a time, checks the nonce marker and tag, discards blocks that carry no nonce, and forwards nonce-bearing blocks as 10-word framed records on a valid/ready stream to the host-side nonce FIFO. It also keeps saturating status counters for the register file.

Parameters:
BLOCK_LEN, 11, words per readback block.
MARK_IDX, 9, index of the nonce-marker word within a block.
MARK, 32'hbeafbeaf, marker value meaning "nonce present".
TAG, 8'h12, required value of bits [15:8] of the last word.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
reg_rst  in  1  synchronous soft reset from the register file
rx_fifo_empty  in  1  RX FIFO empty; FIFO is first-word-fall-through
rx_fifo_dout  in  32  RX FIFO head word; valid whenever rx_fifo_empty=0
rx_fifo_rd_en  out  1  pop RX FIFO head this cycle
out_vld  out  1  output word valid
out_rdy  in  1  downstream ready
out_dat  out  32  output word
out_last  out  1  marks the final word of a record
miner_id  out  4  bits [3:0] of the last word of the most recently forwarded block
cnt_nonce  out  16  number of blocks forwarded
cnt_empty  out  16  number of blocks dropped because the marker was absent
cnt_err  out  16  number of blocks dropped because the marker matched but the tag did not

Behaviour:
- Reset (rst or reg_rst): state COLLECT, word index 0, out_vld=0, out_last=0, out_dat=0, miner_id=0, all counters 0. rx_fifo_rd_en is 0 during reset.
- reg_rst mid-block: discard the partial block. Collection restarts at index 0 on the next non-empty FIFO cycle.
- States: COLLECT, CHECK, SEND.
- COLLECT:
  - rx_fifo_rd_en = (state==COLLECT) && ~rx_fifo_empty. This is combinational, with no registered delay.
  - On each pop, store rx_fifo_dout in buf[idx] and increment idx (4 bits).
  - When a pop occurs with idx==BLOCK_LEN-1, set idx to 0 and go to CHECK on the next cycle.
  - If the FIFO goes empty mid-block, idx holds and collection resumes when data returns. There is no timeout.
- CHECK (exactly one cycle, rx_fifo_rd_en=0):
  - If buf[MARK_IDX]!=MARK: cnt_empty++, next state COLLECT.
  - Else if buf[BLOCK_LEN-1][15:8]!=TAG: cnt_err++, next state COLLECT.
  - Otherwise: cnt_nonce++, miner_id <= buf[BLOCK_LEN-1][3:0], next state SEND, out_vld=1, out_dat=buf[0].
- All counters saturate at 16'hffff and never wrap.
- Timing: if the last pop is in cycle t, CHECK is cycle t+1.
  - Forward case: out_vld is first high in cycle t+2.
  - Drop case: COLLECT resumes in cycle t+2, so the earliest next pop is t+2.
- SEND:
  - Emit buf words 0..BLOCK_LEN-1 in order, skipping MARK_IDX: 10 beats for the default parameters.
  - A beat transfers when out_vld && out_rdy. On a transfer, advance to the next non-marker word in the following cycle.
  - out_dat and out_last are held stable while out_vld=1 && out_rdy=0.
  - out_last=1 only on the word at index BLOCK_LEN-1.
  - A transfer with out_last=1 deasserts out_vld next cycle and returns to COLLECT.
  - No back-to-back bubble is required within a record. With out_rdy held high, 10 consecutive beats occur.
- No FIFO reads during CHECK or SEND. The RX FIFO absorbs the backlog; the controller throttles on RX FIFO level.
- buf is a 32-bit x BLOCK_LEN register array. No reset is needed on buf contents.

Test Plan:
- Good block: push 11 words, w0..w8=32'h1000_0000+i, w9=32'hbeafbeaf, w10=32'habcd_1203, out_rdy=1 -> 10 beats w0..w8 then w10 with out_last on w10; miner_id=3, cnt_nonce=1, out_vld first high 2 cycles after the last pop.
- Empty block: the same block with w9=0 -> no out_vld, cnt_empty=1, and the next block's first pop occurs 2 cycles after the last pop.
- Tag error: w9=marker, w10=32'habcd_3405 -> no output, cnt_err=1, miner_id unchanged.
- Backpressure: good block with out_rdy toggling 1,0,0,1,... -> every word appears exactly once in order; out_dat is stable while stalled; rx_fifo_rd_en=0 for the whole SEND period even with FIFO data pending.
- Streaming: 3 blocks back-to-back (good, empty, good with miner_id 7) with FIFO gaps inserted mid-block -> 20 output beats, cnt_nonce=2, cnt_empty=1, final miner_id=7.
- Soft reset: assert reg_rst after 5 pops of a block, then push a full good block -> the partial data is never emitted, counters read 0 then cnt_nonce=1, and the record matches the second block exactly.

Source files
------------

// File: rtl/api_rx_filter_if.sv
// RX FIFO pop port and framed nonce record stream of api_rx_filter.
// The filter takes the master side; the FIFO and the host stream take the slave side.
interface api_rx_filter_if;
    logic        rx_fifo_empty;
    logic [31:0] rx_fifo_dout;
    logic        rx_fifo_rd_en;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_dat;
    logic        out_last;

    modport master (
        input  rx_fifo_empty, rx_fifo_dout, out_rdy,
        output rx_fifo_rd_en, out_vld, out_dat, out_last
    );
    modport slave (
        output rx_fifo_empty, rx_fifo_dout, out_rdy,
        input  rx_fifo_rd_en, out_vld, out_dat, out_last
    );
endinterface

// File: rtl/api_rx_filter.sv
// Collects miner readback blocks from the RX FIFO, drops blocks without a valid
// nonce, and forwards the rest (minus the marker word) as framed records.
module api_rx_filter #(
    parameter int          BLOCK_LEN = 11,
    parameter int          MARK_IDX  = 9,
    parameter logic [31:0] MARK      = 32'hbeafbeaf,
    parameter logic [7:0]  TAG       = 8'h12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_rst,
    api_rx_filter_if.master bus,
    output logic [3:0]      miner_id,
    output logic [15:0]     cnt_nonce,
    output logic [15:0]     cnt_empty,
    output logic [15:0]     cnt_err
);
    typedef enum logic [1:0] {COLLECT, CHECK, SEND} state_e;

    localparam logic [3:0] LAST_IDX  = 4'(BLOCK_LEN - 1);
    localparam logic [3:0] MARK_I    = 4'(MARK_IDX);
    localparam logic [3:0] FIRST_IDX = (MARK_IDX == 0) ? 4'd1 : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] blk_q [BLOCK_LEN];
    logic [31:0] blk_d [BLOCK_LEN];
    logic        out_vld_q, out_vld_d;
    logic [31:0] out_dat_q, out_dat_d;
    logic        out_last_q, out_last_d;
    logic [3:0]  miner_id_q, miner_id_d;
    logic [15:0] cnt_nonce_q, cnt_nonce_d;
    logic [15:0] cnt_empty_q, cnt_empty_d;
    logic [15:0] cnt_err_q, cnt_err_d;

    logic       pop, xfer, mark_ok, tag_ok;
    logic [3:0] nxt_idx;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    // Pop is gated by both resets so nothing leaves the FIFO while state is being cleared.
    assign pop     = (state_q == COLLECT) && !bus.rx_fifo_empty && !reg_rst && !rst;
    assign xfer    = out_vld_q && bus.out_rdy;
    assign mark_ok = (blk_q[MARK_IDX] == MARK);
    assign tag_ok  = (blk_q[BLOCK_LEN-1][15:8] == TAG);
    assign nxt_idx = ((idx_q + 4'd1) == MARK_I) ? idx_q + 4'd2 : idx_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            idx_q       <= 4'd0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= 32'd0;
            out_last_q  <= 1'b0;
            miner_id_q  <= 4'd0;
            cnt_nonce_q <= 16'd0;
            cnt_empty_q <= 16'd0;
            cnt_err_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            out_last_q  <= out_last_d;
            miner_id_q  <= miner_id_d;
            cnt_nonce_q <= cnt_nonce_d;
            cnt_empty_q <= cnt_empty_d;
            cnt_err_q   <= cnt_err_d;
        end
    end

    always_ff @(posedge clk) blk_q <= blk_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (pop && idx_q == LAST_IDX) state_d = CHECK;
            CHECK:   state_d = (mark_ok && tag_ok) ? SEND : COLLECT;
            SEND:    if (xfer && out_last_q) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
        if (reg_rst) state_d = COLLECT;
    end

    always_comb begin
        blk_d       = blk_q;
        idx_d       = idx_q;
        out_vld_d   = out_vld_q;
        out_dat_d   = out_dat_q;
        out_last_d  = out_last_q;
        miner_id_d  = miner_id_q;
        cnt_nonce_d = cnt_nonce_q;
        cnt_empty_d = cnt_empty_q;
        cnt_err_d   = cnt_err_q;
        case (state_q)
            COLLECT: if (pop) begin
                blk_d[idx_q] = bus.rx_fifo_dout;
                idx_d        = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
            end
            CHECK: begin
                if (!mark_ok) begin
                    cnt_empty_d = sat_inc(cnt_empty_q);
                end else if (!tag_ok) begin
                    cnt_err_d = sat_inc(cnt_err_q);
                end else begin
                    cnt_nonce_d = sat_inc(cnt_nonce_q);
                    miner_id_d  = blk_q[BLOCK_LEN-1][3:0];
                    out_vld_d   = 1'b1;
                    idx_d       = FIRST_IDX;
                    out_dat_d   = blk_q[FIRST_IDX];
                    out_last_d  = (FIRST_IDX == LAST_IDX);
                end
            end
            SEND: if (xfer) begin
                // idx tracks the word currently presented; the marker slot is hopped over.
                if (out_last_q) begin
                    out_vld_d  = 1'b0;
                    out_last_d = 1'b0;
                    idx_d      = 4'd0;
                end else begin
                    idx_d      = nxt_idx;
                    out_dat_d  = blk_q[nxt_idx];
                    out_last_d = (nxt_idx == LAST_IDX);
                end
            end
            default: ;
        endcase
        if (reg_rst) begin
            idx_d       = 4'd0;
            out_vld_d   = 1'b0;
            out_dat_d   = 32'd0;
            out_last_d  = 1'b0;
            miner_id_d  = 4'd0;
            cnt_nonce_d = 16'd0;
            cnt_empty_d = 16'd0;
            cnt_err_d   = 16'd0;
        end
    end

    assign bus.rx_fifo_rd_en = pop;
    assign bus.out_vld       = out_vld_q;
    assign bus.out_dat       = out_dat_q;
    assign bus.out_last      = out_last_q;
    assign miner_id          = miner_id_q;
    assign cnt_nonce         = cnt_nonce_q;
    assign cnt_empty         = cnt_empty_q;
    assign cnt_err           = cnt_err_q;
endmodule

// File: tb/tb_api_rx_filter.sv
// Bench for api_rx_filter: a FIFO model feeds readback blocks, the record stream is
// captured and compared with records and counters derived from the block-level rules.
module tb_api_rx_filter;
    localparam logic [31:0] MARK = 32'hbeafbeaf;
    typedef logic [31:0] blk_t [11];

    logic        clk = 1'b0;
    logic        rst, reg_rst;
    logic [3:0]  miner_id;
    logic [15:0] cnt_nonce, cnt_empty, cnt_err;

    api_rx_filter_if bus();

    api_rx_filter dut (
        .clk       (clk),
        .rst       (rst),
        .reg_rst   (reg_rst),
        .bus       (bus),
        .miner_id  (miner_id),
        .cnt_nonce (cnt_nonce),
        .cnt_empty (cnt_empty),
        .cnt_err   (cnt_err)
    );

    always #5 clk = ~clk;

    logic [31:0] fifo_q [$];
    logic [31:0] cap_dat [$];
    logic        cap_last [$];
    logic [31:0] exp_dat [$];
    logic        exp_last [$];
    int          pop_cyc [$];
    int          vld_rise [$];
    int          cyc, errs, checks, rdy_mode, rdy_cnt, stall_bad, rd_in_send;
    int          exp_nonce, exp_empty, exp_err;
    logic [3:0]  exp_miner;
    bit          gap_en, pop_pend, vld_prev, prev_stall, prev_last;
    logic [31:0] prev_dat;

    // Environment: FIFO head and out_rdy change on the falling edge, observation 1ns later.
    initial begin
        bus.rx_fifo_empty = 1'b1;
        bus.rx_fifo_dout  = 32'd0;
        bus.out_rdy       = 1'b0;
        cyc = 0; rdy_cnt = 0; stall_bad = 0; rd_in_send = 0;
        pop_pend = 0; vld_prev = 0; prev_stall = 0; prev_last = 0; prev_dat = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pop_pend) void'(fifo_q.pop_front());
            if (fifo_q.size() == 0 || (gap_en && $urandom_range(0, 2) == 0)) begin
                bus.rx_fifo_empty = 1'b1;
                bus.rx_fifo_dout  = $urandom;
            end else begin
                bus.rx_fifo_empty = 1'b0;
                bus.rx_fifo_dout  = fifo_q[0];
            end
            case (rdy_mode)
                0:       bus.out_rdy = 1'b1;
                1:       bus.out_rdy = (rdy_cnt % 3 == 0);
                default: bus.out_rdy = 1'($urandom_range(0, 1));
            endcase
            rdy_cnt++;
            #1;
            pop_pend = bus.rx_fifo_rd_en;
            if (pop_pend) pop_cyc.push_back(cyc);
            if (bus.out_vld && !vld_prev) vld_rise.push_back(cyc);
            if (prev_stall && (!bus.out_vld || bus.out_dat !== prev_dat || bus.out_last !== prev_last))
                stall_bad++;
            if (bus.out_vld && bus.rx_fifo_rd_en) rd_in_send++;
            if (bus.out_vld && bus.out_rdy) begin
                cap_dat.push_back(bus.out_dat);
                cap_last.push_back(bus.out_last);
            end
            prev_stall = bus.out_vld && !bus.out_rdy;
            prev_dat   = bus.out_dat;
            prev_last  = bus.out_last;
            vld_prev   = bus.out_vld;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a block is forwarded iff word 9 is the marker and word 10 carries the tag.
    task automatic send_block(input blk_t w);
        for (int i = 0; i < 11; i++) fifo_q.push_back(w[i]);
        if (w[9] != MARK) exp_empty++;
        else if (w[10][15:8] != 8'h12) exp_err++;
        else begin
            exp_nonce++;
            exp_miner = w[10][3:0];
            for (int i = 0; i < 11; i++)
                if (i != 9) begin
                    exp_dat.push_back(w[i]);
                    exp_last.push_back(i == 10);
                end
        end
    endtask

    function automatic blk_t rnd_block(input int kind, input logic [3:0] miner);
        blk_t w;
        for (int i = 0; i < 11; i++) w[i] = $urandom;
        w[10][15:8] = 8'h12;
        w[10][3:0]  = miner;
        w[9]        = MARK;
        if (kind == 1) w[9] = MARK ^ (32'($urandom_range(1, 255)) << 4);
        if (kind == 2) w[10][15:8] = 8'h12 ^ 8'($urandom_range(1, 255));
        return w;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0, quiet = 0;
        while (quiet < 6 && n < 3000) begin
            @(negedge clk); #2;
            n++;
            if (fifo_q.size() == 0 && !bus.out_vld && !pop_pend) quiet++;
            else quiet = 0;
        end
        chk({tag, " idle"}, 64'(quiet >= 6), 64'd1);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, " beats"}, 64'(cap_dat.size()), 64'(exp_dat.size()));
        for (int i = 0; i < cap_dat.size() && i < exp_dat.size(); i++) begin
            chk($sformatf("%s dat[%0d]", tag, i), 64'(cap_dat[i]), 64'(exp_dat[i]));
            chk($sformatf("%s last[%0d]", tag, i), 64'(cap_last[i]), 64'(exp_last[i]));
        end
        chk({tag, " cnt_nonce"}, 64'(cnt_nonce), 64'(exp_nonce));
        chk({tag, " cnt_empty"}, 64'(cnt_empty), 64'(exp_empty));
        chk({tag, " cnt_err"},   64'(cnt_err),   64'(exp_err));
        chk({tag, " miner_id"},  64'(miner_id),  64'(exp_miner));
        cap_dat.delete(); cap_last.delete(); exp_dat.delete(); exp_last.delete();
        pop_cyc.delete(); vld_rise.delete();
    endtask

    initial begin
        blk_t w;
        int   n;
        errs = 0; checks = 0; exp_nonce = 0; exp_empty = 0; exp_err = 0; exp_miner = 4'd0;
        rdy_mode = 0; gap_en = 0;
        rst = 1'b1; reg_rst = 1'b0;

        // Reset with a full good block already waiting in the FIFO.
        for (int i = 0; i < 9; i++) w[i] = 32'h1000_0000 + 32'(i);
        w[9] = MARK; w[10] = 32'habcd_1203;
        send_block(w);
        repeat (3) @(negedge clk);
        #2;
        chk("rst rd_en",     64'(bus.rx_fifo_rd_en), 64'd0);
        chk("rst pops",      64'(pop_cyc.size()), 64'd0);
        chk("rst out_vld",   64'(bus.out_vld), 64'd0);
        chk("rst out_last",  64'(bus.out_last), 64'd0);
        chk("rst out_dat",   64'(bus.out_dat), 64'd0);
        chk("rst miner_id",  64'(miner_id), 64'd0);
        chk("rst cnt_nonce", 64'(cnt_nonce), 64'd0);
        chk("rst cnt_empty", 64'(cnt_empty), 64'd0);
        chk("rst cnt_err",   64'(cnt_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        wait_idle("good");
        chk("good pops", 64'(pop_cyc.size()), 64'd11);
        if (pop_cyc.size() == 11 && vld_rise.size() > 0)
            chk("good vld latency", 64'(vld_rise[0] - pop_cyc[10]), 64'd2);
        else
            chk("good vld seen", 64'(vld_rise.size()), 64'd1);
        compare_all("good");

        // Empty block followed at once by a good one: next pop two cycles after the last.
        w[9] = 32'd0;
        send_block(w);
        send_block(rnd_block(0, 4'($urandom_range(0, 15))));
        wait_idle("empty");
        chk("empty pops", 64'(pop_cyc.size()), 64'd22);
        if (pop_cyc.size() >= 12)
            chk("empty resume gap", 64'(pop_cyc[11] - pop_cyc[10]), 64'd2);
        compare_all("empty");

        for (int i = 0; i < 9; i++) w[i] = 32'h1000_0000 + 32'(i);
        w[9] = MARK; w[10] = 32'habcd_3405;
        send_block(w);
        wait_idle("tagerr");
        compare_all("tagerr");

        // Backpressure, with a second block pending in the FIFO during SEND.
        rdy_mode = 1;
        send_block(rnd_block(0, 4'd5));
        send_block(rnd_block(0, 4'd9));
        wait_idle("bp");
        chk("bp stall stable", 64'(stall_bad), 64'd0);
        chk("bp no rd in send", 64'(rd_in_send), 64'd0);
        compare_all("bp");

        rdy_mode = 2; gap_en = 1;
        send_block(rnd_block(0, 4'd2));
        send_block(rnd_block(1, 4'd4));
        send_block(rnd_block(0, 4'd7));
        wait_idle("stream");
        compare_all("stream");

        for (int k = 0; k < 6; k++) begin
            rdy_mode = $urandom_range(0, 2);
            send_block(rnd_block($urandom_range(0, 2), 4'($urandom_range(0, 15))));
        end
        wait_idle("rand");
        compare_all("rand");
        chk("rand stall stable", 64'(stall_bad), 64'd0);
        chk("rand no rd in send", 64'(rd_in_send), 64'd0);

        // Soft reset after 5 pops of a block: partial data must never reach the output.
        rdy_mode = 0; gap_en = 0;
        w = rnd_block(0, 4'd11);
        for (int i = 0; i < 5; i++) fifo_q.push_back(w[i]);
        n = 0;
        while (pop_cyc.size() < 5 && n < 200) begin
            @(negedge clk); #2;
            n++;
        end
        chk("srst partial pops", 64'(pop_cyc.size()), 64'd5);
        @(negedge clk);
        reg_rst = 1'b1;
        @(negedge clk); #2;
        exp_nonce = 0; exp_empty = 0; exp_err = 0; exp_miner = 4'd0;
        chk("srst rd_en",     64'(bus.rx_fifo_rd_en), 64'd0);
        chk("srst cnt_nonce", 64'(cnt_nonce), 64'd0);
        chk("srst cnt_empty", 64'(cnt_empty), 64'd0);
        chk("srst cnt_err",   64'(cnt_err), 64'd0);
        chk("srst miner_id",  64'(miner_id), 64'd0);
        reg_rst = 1'b0;
        send_block(rnd_block(0, 4'd6));
        wait_idle("srst");
        compare_all("srst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
